// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: start/restart on Go, advance on End,
// branch load, stall, and wrap-or-halt when the last program address is consumed.
module pc_sequencer #(
  parameter int unsigned AW   = 8,
  parameter int unsigned LAST = (1 << AW) - 1,
  parameter bit          WRAP = 1'b0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Go,
  input  logic [AW-1:0] Start,
  input  logic          End,
  input  logic          BrEn,
  input  logic [AW-1:0] BrTarget,
  input  logic          Stall,
  output logic [AW-1:0] Next,
  output logic          Valid,
  output logic          Halted,
  output logic          Wrapped
);

  localparam int unsigned XW = AW + 1;
  localparam logic [AW-1:0] LAST_A = AW'(LAST);
  // One extra bit keeps the legality compare meaningful when LAST is the top address.
  localparam logic [XW-1:0] LAST_X = XW'(LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] next_q, next_d;
  logic [AW-1:0] base_q, base_d;
  logic          valid_q, halted_q, wrapped_q;
  logic          wrapped_d;
  logic          start_ok, target_ok;

  assign start_ok  = ({1'b0, Start} <= LAST_X);
  assign target_ok = ({1'b0, BrTarget} <= LAST_X);

  // Next-state and datapath update; Go takes precedence in every state.
  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    base_d    = base_q;
    wrapped_d = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (Go) begin
          next_d  = Start;
          base_d  = Start;
          state_d = start_ok ? RUN : HALT;
        end
      end
      RUN: begin
        if (Go) begin
          next_d  = Start;
          base_d  = Start;
          state_d = start_ok ? RUN : HALT;
        end else if (!Stall && End) begin
          if (BrEn) begin
            if (target_ok) next_d = BrTarget;
            else           state_d = HALT;
          end else if (next_q < LAST_A) begin
            next_d = next_q + AW'(1);
          end else if (WRAP) begin
            next_d    = base_q;
            wrapped_d = 1'b1;
          end else begin
            state_d = HALT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; status flags are registered from the next state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      next_q    <= '0;
      base_q    <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      base_q    <= base_d;
      valid_q   <= (state_d == RUN);
      halted_q  <= (state_d == HALT);
      wrapped_q <= wrapped_d;
    end
  end

  assign Next    = next_q;
  assign Valid   = valid_q;
  assign Halted  = halted_q;
  assign Wrapped = wrapped_q;

endmodule
